hdc_fold_assembler: RTL

Parametrised fold-domain fuser for the folded HDC sensor-fusion pipeline. It sits between the spatial encoder and the temporal encoder. It accepts FOLD_WIDTH-bit spatial hypervector slices for NUM_MODALITIES modalities, fold by fold, and takes a per-bit majority across modalities for each fold. It assembles the NUM_FOLDS fused slices into one HV_DIMENSION-bit hypervector and hands it off through a double-buffered valid/ready output, so the next window can start accumulating while the previous result is held.

---
 rtl/hdc_fold_pkg.sv | 22 ++
 rtl/hdc_majority_bank.sv | 41 ++++
 rtl/hdc_fold_assembler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hdc_fold_pkg.sv
// Shared types and the per-bit majority rule for the fold assembler.
// Pure declarations; no state, no timing.
package hdc_fold_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} fold_state_e;

  // Up to 8 modalities, so a count never exceeds 8 and fits in 4 bits.
  localparam int CNT_MAX_W = 4;

  function automatic logic majority(input logic [CNT_MAX_W-1:0] cnt,
                                    input int num_mod,
                                    input logic tie_break);
    int twice;
    logic bit_out;
    twice = {27'd0, cnt, 1'b0};
    if (twice > num_mod) bit_out = 1'b1;
    else if (twice == num_mod) bit_out = tie_break;
    else bit_out = 1'b0;
    return bit_out;
  endfunction

endpackage

// File: rtl/hdc_majority_bank.sv
// Per-bit ones counters for one fold; fused slice is combinational and includes the current slice.
// Counters clear on clr or on the last modality's add; no backpressure of its own.
module hdc_majority_bank
  import hdc_fold_pkg::*;
#(
  parameter int FOLD_WIDTH     = 250,
  parameter int NUM_MODALITIES = 3,
  parameter int CNT_WIDTH      = 3,
  parameter bit TIE_BREAK      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add,
  input  logic                  last,
  input  logic [FOLD_WIDTH-1:0] slice,
  output logic [FOLD_WIDTH-1:0] fused
);

  logic [CNT_WIDTH-1:0] cnt_q [FOLD_WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [FOLD_WIDTH];

  always_comb begin
    for (int i = 0; i < FOLD_WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      fused[i] = majority(CNT_MAX_W'(cnt_q[i]) + CNT_MAX_W'(slice[i]),
                          NUM_MODALITIES, TIE_BREAK);
      if (clr || (add && last)) cnt_d[i] = '0;
      else if (add) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(slice[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FOLD_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hdc_fold_assembler.sv
// Fuses modality slices per fold by majority and assembles a full hypervector; result valid the cycle after the final slice.
// Double-buffered output: input stalls (HOLD) only when a finished window meets a still-occupied output register.
module hdc_fold_assembler
  import hdc_fold_pkg::*;
#(
  parameter int NUM_FOLDS            = 8,
  parameter int NUM_FOLDS_WIDTH      = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  parameter int FOLD_WIDTH           = 250,
  parameter int NUM_MODALITIES       = 3,
  parameter int NUM_MODALITIES_WIDTH = (NUM_MODALITIES > 1) ? $clog2(NUM_MODALITIES) : 1,
  parameter bit TIE_BREAK            = 1'b0,
  parameter int HV_DIMENSION         = NUM_FOLDS * FOLD_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            hvin_valid,
  output logic                            hvin_ready,
  input  logic [FOLD_WIDTH-1:0]           hvin,
  input  logic [NUM_FOLDS_WIDTH-1:0]      fold_idx,
  input  logic [NUM_MODALITIES_WIDTH-1:0] mod_idx,
  output logic                            hvout_valid,
  input  logic                            hvout_ready,
  output logic [HV_DIMENSION-1:0]         hvout,
  output logic                            order_err
);

  localparam logic [NUM_MODALITIES_WIDTH-1:0] LAST_MOD  = NUM_MODALITIES_WIDTH'(NUM_MODALITIES - 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0]      LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  fold_state_e                     state_q, state_d;
  logic [NUM_FOLDS_WIDTH-1:0]      exp_fold_q, exp_fold_d;
  logic [NUM_MODALITIES_WIDTH-1:0] exp_mod_q, exp_mod_d;
  logic [HV_DIMENSION-1:0]         asm_q, asm_d;
  logic [HV_DIMENSION-1:0]         hvout_q, hvout_d;
  logic                            hvout_valid_q, hvout_valid_d;
  logic                            order_err_q, order_err_d;
  logic                            accept, last_mod, last_fold, out_free, bank_clr;
  logic [FOLD_WIDTH-1:0]           fused;

  assign hvin_ready = (state_q == ACCUM) && !flush && !rst;
  assign accept     = hvin_valid && hvin_ready;
  assign last_mod   = (exp_mod_q == LAST_MOD);
  assign last_fold  = (exp_fold_q == LAST_FOLD);
  assign out_free   = !hvout_valid_q || hvout_ready;
  assign bank_clr   = (state_q == ACCUM) && flush;

  hdc_majority_bank #(
    .FOLD_WIDTH    (FOLD_WIDTH),
    .NUM_MODALITIES(NUM_MODALITIES),
    .CNT_WIDTH     (NUM_MODALITIES_WIDTH + 1),
    .TIE_BREAK     (TIE_BREAK)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .clr  (bank_clr),
    .add  (accept),
    .last (last_mod),
    .slice(hvin),
    .fused(fused)
  );

  always_comb begin
    state_d       = state_q;
    exp_fold_d    = exp_fold_q;
    exp_mod_d     = exp_mod_q;
    asm_d         = asm_q;
    hvout_d       = hvout_q;
    hvout_valid_d = hvout_valid_q;
    order_err_d   = order_err_q;

    if (hvout_valid_q && hvout_ready) hvout_valid_d = 1'b0;

    case (state_q)
      ACCUM: begin
        if (flush) begin
          exp_fold_d = '0;
          exp_mod_d  = '0;
          asm_d      = '0;
        end else if (accept) begin
          // Tags are only audited; placement always follows the expected position.
          if (fold_idx != exp_fold_q || mod_idx != exp_mod_q) order_err_d = 1'b1;
          if (last_mod) begin
            asm_d[exp_fold_q*FOLD_WIDTH +: FOLD_WIDTH] = fused;
            exp_mod_d = '0;
            if (last_fold) begin
              exp_fold_d = '0;
              if (out_free) begin
                hvout_d       = asm_d;
                hvout_valid_d = 1'b1;
              end else begin
                state_d = HOLD;
              end
            end else begin
              exp_fold_d = exp_fold_q + 1'b1;
            end
          end else begin
            exp_mod_d = exp_mod_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          hvout_d       = asm_q;
          hvout_valid_d = 1'b1;
          state_d       = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      exp_fold_q    <= '0;
      exp_mod_q     <= '0;
      asm_q         <= '0;
      hvout_q       <= '0;
      hvout_valid_q <= 1'b0;
      order_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_fold_q    <= exp_fold_d;
      exp_mod_q     <= exp_mod_d;
      asm_q         <= asm_d;
      hvout_q       <= hvout_d;
      hvout_valid_q <= hvout_valid_d;
      order_err_q   <= order_err_d;
    end
  end

  assign hvout       = hvout_q;
  assign hvout_valid = hvout_valid_q;
  assign order_err   = order_err_q;

endmodule
